// File: rtl/demodulator_pkg.sv
// Shared constants for the carrier modulator/demodulator pair: FSM encoding,
// default half-period width and the lock-window tolerance shift.
package demodulator_pkg;

    localparam int CPH_W_DEF = 16;
    localparam int TOL_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Settings the UART modulator and this demodulator must agree on.
    typedef struct packed {
        logic [CPH_W_DEF-1:0] cycles_per_half_period;
        logic                 idle_level;
    } mod_params_t;

endpackage

// File: rtl/demodulator_if.sv
// Carrier-in / lock-status bundle between the delay line, the demodulator
// and whatever consumes the recovered data.
interface demodulator_if
    import demodulator_pkg::*;
#(
    parameter int CPH_W = CPH_W_DEF
) ();
    logic             in;
    logic [CPH_W-1:0] cycles_per_half_period;
    logic             out;
    logic [7:0]       locked_edges;
    logic             err;

    modport master (
        output in, cycles_per_half_period,
        input  out, locked_edges, err
    );

    modport slave (
        input  in, cycles_per_half_period,
        output out, locked_edges, err
    );
endinterface

// File: rtl/demodulator_sync_edge_det.sv
// Synchroniser, optional 3-sample majority filter (DEMOD_GLITCH_FILTER_EN)
// and edge pulse generation for the raw carrier input.
module demodulator_sync_edge_det (
    input  logic clk,
    input  logic n_reset,
    input  logic i_run,
    input  logic i_in,
    output logic o_edge
);
    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_level;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync <= '0;
        end else if (i_run) begin
            r_sync <= {r_sync[0], i_in};
        end
    end

`ifdef DEMOD_GLITCH_FILTER_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_hist <= '0;
        end else if (i_run) begin
            r_hist <= {r_hist[0], r_sync[1]};
        end
    end

    // Level only moves once two of the last three samples agree.
    assign w_level = (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) |
                     (r_hist[0] & r_hist[1]);
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_prev <= 1'b0;
        end else if (i_run) begin
            r_prev <= w_level;
        end
    end

    assign o_edge = i_run & (w_level ^ r_prev);
endmodule

// File: rtl/demodulator.sv
// Carrier lock detector: measures edge gaps against H = cph + 1 and reports
// lock on out. Build with DEMOD_GLITCH_FILTER_EN for the input majority filter.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no carrier seen; waiting for any edge
// ST_ACQUIRE | counting consecutive in-tolerance gaps towards LOCK_GAPS
// ST_LOCKED  | carrier present; out = 1
module demodulator
    import demodulator_pkg::*;
#(
    parameter int CPH_W     = CPH_W_DEF,
    parameter int LOCK_GAPS = 3
) (
    input  logic         clk,
    input  logic         n_reset,
    demodulator_if.slave bus
);
    localparam int         GW = CPH_W + 2;
    localparam logic [7:0] LG = 8'(LOCK_GAPS);

    logic [1:0]       r_rst_sync;
    logic             w_run;
    logic             w_edge;
    logic             w_cph_chg;
    logic             w_in_tol;
    logic             w_timeout;
    logic [GW-1:0]    w_h;
    logic [GW-1:0]    w_lo;
    logic [GW-1:0]    w_hi;
    logic [GW-1:0]    w_two_h;
    logic [GW-1:0]    w_gap;
    logic [GW-1:0]    r_gap;
    logic [CPH_W-1:0] r_cph;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_good;
    logic [7:0]       w_good_nxt;
    logic [7:0]       r_locked_edges;
    logic [7:0]       w_le_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_out;

    // Assertion clears everything at once; release reaches the logic two clocks later.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

    demodulator_sync_edge_det u_sync_edge_det (
        .clk     (clk),
        .n_reset (n_reset),
        .i_run   (w_run),
        .i_in    (bus.in),
        .o_edge  (w_edge)
    );

    assign w_h       = {2'b00, bus.cycles_per_half_period} + GW'(1);
    assign w_lo      = w_h - (w_h >> TOL_SHIFT);
    assign w_hi      = w_h + (w_h >> TOL_SHIFT);
    assign w_two_h   = w_h << 1;
    // Gap as seen at this edge: clocks since the previous edge, saturating.
    assign w_gap     = (&r_gap) ? r_gap : r_gap + GW'(1);
    assign w_in_tol  = (w_gap >= w_lo) && (w_gap <= w_hi);
    assign w_timeout = !w_edge && (w_gap >= w_two_h);
    assign w_cph_chg = (bus.cycles_per_half_period != r_cph);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else if (w_run) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cph_chg) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) w_state_nxt = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (w_edge) begin
                        if (w_in_tol && ((r_good + 8'd1) >= LG)) w_state_nxt = ST_LOCKED;
                    end else if (w_timeout) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (w_edge) begin
                        if (!w_in_tol) w_state_nxt = ST_ACQUIRE;
                    end else if (w_timeout) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_good_nxt = r_good;
        w_le_nxt   = r_locked_edges;
        w_err_nxt  = 1'b0;
        if (w_state_nxt == ST_IDLE) begin
            w_good_nxt = '0;
            w_le_nxt   = '0;
        end else if (w_edge && (r_state != ST_IDLE)) begin
            if (w_in_tol) begin
                if (r_state == ST_ACQUIRE) w_good_nxt = r_good + 8'd1;
                if (r_locked_edges != 8'hFF) w_le_nxt = r_locked_edges + 8'd1;
            end else begin
                w_good_nxt = '0;
                w_le_nxt   = '0;
                w_err_nxt  = (r_state == ST_LOCKED);
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_gap          <= '0;
            r_cph          <= '0;
            r_good         <= '0;
            r_locked_edges <= '0;
            r_err          <= 1'b0;
            r_out          <= 1'b0;
        end else if (w_run) begin
            if (w_cph_chg || w_edge) begin
                r_gap <= '0;
            end else if (!(&r_gap)) begin
                r_gap <= r_gap + GW'(1);
            end
            r_cph          <= bus.cycles_per_half_period;
            r_good         <= w_good_nxt;
            r_locked_edges <= w_le_nxt;
            r_err          <= w_err_nxt;
            r_out          <= (w_state_nxt == ST_LOCKED);
        end
    end

    assign bus.out          = r_out;
    assign bus.locked_edges = r_locked_edges;
    assign bus.err          = r_err;
endmodule
